latch_bank_wr_sched: RTL
========================

// Module: latch_bank_wr_sched
//
// PURPOSE
//   Round-robin write scheduler for a shared bank of NENT level-sensitive D latches.
//   Accepts write requests from NREQ requesters via valid/ready.
//   Each accepted write runs a timed sequence: data setup, enable pulse, data hold.
//   The latch bank is therefore never opened while its data input is changing.
//   Sits between requester logic and the latch array; sole driver of lat_d and lat_en.
//
// PARAMETERS
//   NREQ      4   number of requesters (>=2)
//   DW        8   data width of one latch entry
//   NENT      8   number of latch entries in the bank
//   AW        3   entry address width, $clog2(NENT)
//   OPEN_CYC  1   cycles lat_en stays high per write (>=1)
//
// PORTS
//   clk          in   1          clock, rising edge
//   rstn         in   1          reset, synchronous, active-low
//   req_valid    in   NREQ       per-requester write request
//   req_addr     in   NREQ*AW    entry address, requester i at [i*AW +: AW]
//   req_data     in   NREQ*DW    write data, requester i at [i*DW +: DW]
//   req_ready    out  NREQ       one-hot accept; transfer when valid & ready
//   lat_d        out  DW         data bus to all latch D inputs
//   lat_en       out  NENT       one-hot latch enables
//   busy         out  1          high in any state other than IDLE
//   wr_done      out  1          1-cycle pulse in HOLD
//   wr_done_id   out  $clog2(NREQ)  requester index of the completed write, valid with wr_done
//
// BEHAVIOUR
//   Reset values: all outputs 0, state IDLE, rr_ptr 0, open counter 0.
//   Reset applies at the next clk edge from any state, including mid-OPEN.
//   FSM: IDLE -> SETUP -> OPEN -> HOLD -> IDLE.
//   IDLE:
//     - If any req_valid is set, grant the first set index at or above rr_ptr, wrapping modulo NREQ.
//     - req_ready[grant] is combinationally high in that cycle; no other bit is set.
//     - Capture addr, data and grant id; rr_ptr <= (grant+1) mod NREQ.
//     - Go to SETUP.
//     - If no req_valid is set, stay in IDLE; req_ready is all 0.
//   SETUP (1 cycle): lat_d = captured data; lat_en = 0.
//   OPEN (OPEN_CYC cycles): lat_en[addr] = 1, all other bits 0; lat_d held.
//   HOLD (1 cycle): lat_en = 0; lat_d held; wr_done = 1; wr_done_id = grant.
//   lat_d is registered and changes only on the IDLE->SETUP edge.
//   lat_d keeps its last value while in IDLE.
//   req_ready is 0 in SETUP, OPEN and HOLD; requests are only accepted in IDLE.
//   Timing with accept at cycle t:
//     - SETUP at t+1.
//     - lat_en high for cycles t+2 .. t+1+OPEN_CYC.
//     - wr_done at t+2+OPEN_CYC.
//     - Next accept no earlier than t+3+OPEN_CYC.
//   Address rule: addr >= NENT is dropped silently.
//     - lat_en stays 0 for that write.
//     - The sequence and wr_done still occur.
//   A requester that drops valid before it is granted is simply not served.
//   Changes to req_addr/req_data after the accept are ignored.
//   At most one lat_en bit is ever high; lat_en is never high in the same cycle lat_d changes.
//
// TESTING
//   1. Single request: req_valid=0001, addr=5, data=A5 at t.
//      -> req_ready=0001 at t; lat_d=A5 from t+1; lat_en=0x20 only at t+2.
//      -> wr_done=1 and wr_done_id=0 at t+3.
//   2. Contention: req_valid=1111 held, distinct data, rr_ptr=0.
//      -> grants in order 0,1,2,3,0; one grant every 4 cycles.
//   3. Rotation: after a grant to 2, present req_valid=1001.
//      -> grant 3, then grant 0.
//   4. OPEN_CYC=3: lat_en high for exactly 3 cycles.
//      -> lat_d unchanged from SETUP through HOLD; wr_done at t+5.
//   5. Reset mid-OPEN: rstn=0 for one cycle.
//      -> next edge: lat_en=0, busy=0, lat_d=0, rr_ptr=0, no wr_done.
//   6. Out-of-range address: NENT=6, AW=3, addr=7.
//      -> lat_en stays 0 throughout; wr_done still pulses at t+3.

Source files
------------

// File: rtl/latch_bank_wr_sched.sv
// Round-robin write scheduler for a bank of level-sensitive latches.
// Each write runs SETUP -> OPEN (OPEN_CYC cycles) -> HOLD, so lat_d is stable whenever lat_en is high.
module latch_bank_wr_sched #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int NENT     = 8,
  parameter int AW       = 3,
  parameter int OPEN_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           lat_d,
  output logic [NENT-1:0]         lat_en,
  output logic                    busy,
  output logic                    wr_done,
  output logic [$clog2(NREQ)-1:0] wr_done_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(OPEN_CYC - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  lat_d_q, lat_d_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;

  // First requesting index at or above rr_q, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[(int'(rr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    id_d      = id_q;
    lat_d_d   = lat_d_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          // A request seen while reset is asserted is never accepted, so do not advertise it.
          req_ready[gnt_idx] = rstn;
          state_d = S_SETUP;
          addr_d  = req_addr[gnt_idx*AW +: AW];
          lat_d_d = req_data[gnt_idx*DW +: DW];
          id_d    = gnt_idx;
          rr_d    = (gnt_idx == ID_LAST) ? '0 : gnt_idx + IDW'(1);
          cnt_d   = '0;
        end
      end
      S_SETUP: state_d = S_OPEN;
      S_OPEN: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the captured address/data/id are reset too; lat_d drives the latch bank and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      lat_d_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      lat_d_q <= lat_d_d;
    end
  end

  // Out-of-range addresses run the full sequence with no enable.
  always_comb begin
    lat_en = '0;
    if (state_q == S_OPEN && int'(addr_q) < NENT) begin
      lat_en = NENT'(1) << addr_q;
    end
  end

  assign lat_d      = lat_d_q;
  assign busy       = (state_q != S_IDLE);
  assign wr_done    = (state_q == S_HOLD);
  assign wr_done_id = wr_done ? id_q : '0;

endmodule
